// File: rtl/csa_pkg.sv
// Shared types and constants for the carry-select add scheduler.
package csa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic id_t;

endpackage

// File: rtl/csa_add_scheduler_if.sv
// Request/response bundle between two clients and the add scheduler.
interface csa_add_scheduler_if
  import csa_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  id_t          rsp_id;
  logic         busy;

  // client side
  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
  );

  // scheduler side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
  );

endinterface

// File: rtl/nibble_csa_slice.sv
// 4-bit carry-select adder: two precomputed ripple sums selected by carry-in.
module nibble_csa_slice
  import csa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] r0, r1;

  // both carry hypotheses evaluated in parallel, carry-in only drives the mux
  always_comb begin
    r0 = {1'b0, a} + {1'b0, b};
    r1 = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, 1'b1};
    {cout, sum} = cin ? r1 : r0;
  end

endmodule

// File: rtl/csa_add_scheduler.sv
// Round-robin arbiter + nibble-serial add sequencer around one shared CSA slice.
module csa_add_scheduler
  import csa_pkg::*;
#(
  parameter int NIBBLES = 4
)(
  input  logic                clk,
  input  logic                rst,
  csa_add_scheduler_if.slave  bus
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] nib_vec_t;

  state_t             state_q, state_d;
  id_t                prio_q,  prio_d;
  id_t                id_q,    id_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  nib_vec_t           a_q,     a_d;
  nib_vec_t           b_q,     b_d;
  nib_vec_t           sum_q,   sum_d;
  logic               carry_q, carry_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               busy_q,  busy_d;

  logic               grant0, grant1;
  logic [NIBBLE_W-1:0] slice_sum;
  logic               slice_cout;

  nibble_csa_slice u_slice (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // round-robin grant; only offered in IDLE and never while reset is held
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_IDLE && !rst) begin
      if (bus.req0_valid && (!bus.req1_valid || prio_q == 1'b0)) grant0 = 1'b1;
      else if (bus.req1_valid)                                     grant1 = 1'b1;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // next-state: accept in IDLE, one nibble per cycle in ADD, hold in DONE
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    id_d        = id_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          a_d     = grant1 ? bus.req1_a   : bus.req0_a;
          b_d     = grant1 ? bus.req1_b   : bus.req0_b;
          carry_d = grant1 ? bus.req1_cin : bus.req0_cin;
          id_d    = grant1;
          prio_d  = grant0;          // loser gets preference next time
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_ADD;
          busy_d  = 1'b1;
        end
      end
      ST_ADD: begin
        sum_d[idx_q] = slice_sum;
        carry_d      = slice_cout;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          idx_d       = '0;
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // all state, async clear aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      id_q        <= id_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = carry_q;
  assign bus.rsp_id    = id_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_csa_add_scheduler.sv
// Directed bench for csa_add_scheduler (NIBBLES=4 main instance, NIBBLES=1 corner instance).
module tb_csa_add_scheduler;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  csa_add_scheduler_if #(.NIBBLES(4)) bus  ();
  csa_add_scheduler_if #(.NIBBLES(1)) bus1 ();

  csa_add_scheduler #(.NIBBLES(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  csa_add_scheduler #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ticks until rsp_valid, bounded; n = edges taken
  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_timeout", {31'd0, bus.rsp_valid}, 32'd1);
  endtask

  task automatic chk_rsp(input string tag, input logic [15:0] s, input logic c, input logic id);
    chk({tag, "_sum"},  {16'd0, bus.rsp_sum}, {16'd0, s});
    chk({tag, "_cout"}, {31'd0, bus.rsp_cout}, {31'd0, c});
    chk({tag, "_id"},   {31'd0, bus.rsp_id},   {31'd0, id});
  endtask

  int n;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_cin = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_cin = 0;
    bus.rsp_ready  = 1;
    bus1.req0_valid = 0; bus1.req0_a = 0; bus1.req0_b = 0; bus1.req0_cin = 0;
    bus1.req1_valid = 0; bus1.req1_a = 0; bus1.req1_b = 0; bus1.req1_cin = 0;
    bus1.rsp_ready  = 1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    bus.req0_valid = 1;
    #1;
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_sum",       {16'd0, bus.rsp_sum},   32'd0);
    chk("rst_ready0",    {31'd0, bus.req0_ready}, 32'd0);
    bus.req0_valid = 0;
    rst = 1'b0;
    tick();

    // single request, latency 4
    bus.req0_valid = 1; bus.req0_a = 16'h1234; bus.req0_b = 16'h4321; bus.req0_cin = 0;
    #1;
    chk("t1_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("t1_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req0_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t1_lat%0d", i), {31'd0, bus.rsp_valid}, (i == 4) ? 32'd1 : 32'd0);
    end
    chk_rsp("t1", 16'h5555, 1'b0, 1'b0);
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("t1_idle_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("t1_idle_busy",  {31'd0, bus.busy},      32'd0);

    // full carry ripple from requester 1
    bus.req1_valid = 1; bus.req1_a = 16'hFFFF; bus.req1_b = 16'h0000; bus.req1_cin = 1;
    tick();
    bus.req1_valid = 0;
    wait_rsp(n);
    chk_rsp("t2", 16'h0000, 1'b1, 1'b1);
    tick();

    // contention: both held valid, grants alternate
    bus.req0_valid = 1; bus.req0_a = 16'h0001; bus.req0_b = 16'h0001; bus.req0_cin = 0;
    bus.req1_valid = 1; bus.req1_a = 16'h8000; bus.req1_b = 16'h8000; bus.req1_cin = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t3_ready0_%0d", k), {31'd0, bus.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_ready1_%0d", k), {31'd0, bus.req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
      wait_rsp(n);
      chk($sformatf("t3_cycles_%0d", k), n, 32'd5);
      if (k % 2 == 0) chk_rsp($sformatf("t3_%0d", k), 16'h0002, 1'b0, 1'b0);
      else            chk_rsp($sformatf("t3_%0d", k), 16'h0000, 1'b1, 1'b1);
      tick();
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;

    // back-pressure: DONE held, input churn ignored
    bus.rsp_ready = 0;
    bus.req0_valid = 1; bus.req0_a = 16'h00FF; bus.req0_b = 16'h0001; bus.req0_cin = 0;
    tick();
    bus.req0_valid = 0;
    wait_rsp(n);
    for (int i = 0; i < 5; i++) begin
      bus.req0_a = 16'hABCD; bus.req1_valid = 1; bus.req1_a = 16'h7777;
      tick();
      chk($sformatf("t4_valid_%0d", i), {31'd0, bus.rsp_valid}, 32'd1);
      chk($sformatf("t4_sum_%0d", i),   {16'd0, bus.rsp_sum},   32'h0100);
      chk($sformatf("t4_rdy1_%0d", i),  {31'd0, bus.req1_ready}, 32'd0);
      chk($sformatf("t4_busy_%0d", i),  {31'd0, bus.busy},      32'd1);
    end
    chk_rsp("t4", 16'h0100, 1'b0, 1'b0);
    bus.req1_valid = 0;
    bus.rsp_ready  = 1;
    tick();
    chk("t4_release_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("t4_release_busy",  {31'd0, bus.busy},      32'd0);

    // reset mid-ADD at idx=2; prio is 1 going in
    bus.req0_valid = 1; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_cin = 0;
    tick();
    bus.req0_valid = 0;
    repeat (2) tick();
    bus.req0_valid = 1; bus.req1_valid = 1;
    rst = 1'b1;
    #1;
    chk("t5_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("t5_busy",  {31'd0, bus.busy},      32'd0);
    chk("t5_sum",   {16'd0, bus.rsp_sum},   32'd0);
    chk("t5_cout",  {31'd0, bus.rsp_cout},  32'd0);
    chk("t5_rdy0",  {31'd0, bus.req0_ready}, 32'd0);
    chk("t5_rdy1",  {31'd0, bus.req1_ready}, 32'd0);
    tick();
    rst = 1'b0;
    bus.req0_a = 16'h0F0F; bus.req0_b = 16'h00F1; bus.req0_cin = 1;
    #1;
    chk("t5_post_rdy0", {31'd0, bus.req0_ready}, 32'd1);
    chk("t5_post_rdy1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    wait_rsp(n);
    chk_rsp("t5", 16'h1001, 1'b0, 1'b0);
    tick();

    // NIBBLES=1 instance: single ADD cycle
    bus1.req0_valid = 1; bus1.req0_a = 4'hF; bus1.req0_b = 4'h1; bus1.req0_cin = 0;
    #1;
    chk("t6_ready0", {31'd0, bus1.req0_ready}, 32'd1);
    tick();
    bus1.req0_valid = 0;
    chk("t6_valid_e0", {31'd0, bus1.rsp_valid}, 32'd0);
    tick();
    chk("t6_valid_e1", {31'd0, bus1.rsp_valid}, 32'd1);
    chk("t6_sum",      {28'd0, bus1.rsp_sum},   32'd0);
    chk("t6_cout",     {31'd0, bus1.rsp_cout},  32'd1);
    tick();
    chk("t6_idle", {31'd0, bus1.rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
